pc_controller: RTL and testbench
================================

Name: pc_controller

Overview:
Program-counter sequencer for the single-issue core. Owns the fetch address presented to mem_program and decides each cycle whether to advance, hold, redirect or halt.
Replaces the free-running PC register in the top level. Takes stall, redirect and halt requests from decode/hazard logic. Drives fetch-valid and flush qualifiers to the IF/ID stage.

Parameters:
RESET_VECTOR, 16'h0000, PC value loaded on reset (bit 0 must be 0)
INSTR_STEP, 16'd2, byte increment per sequential fetch
FLUSH_CYCLES, 2, cycles spent in FLUSH after a redirect (1..7)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (rst==0 resets)
stall  input  1  hazard hold: keep PC, keep current fetch
redirect_valid  input  1  taken branch/jump this cycle
redirect_target  input  16  byte address of redirect destination
halt  input  1  halt instruction decoded
resume  input  1  leave HALTED
pc  output  16  current fetch address to program memory
pc_next_seq  output  16  pc + INSTR_STEP (link value for jumps)
fetch_valid  output  1  instruction at pc may be latched into IF/ID
flush  output  1  squash IF/ID contents
misaligned  output  1  one-cycle pulse: redirect_target[0] was 1
state  output  2  pc_state_e, for debug/trace
fetch_count  output  16  count of sequential advances, wraps

Behaviour:
- All outputs are registered, except pc_next_seq (comb. from pc), fetch_valid (state==RUN) and flush (state==FLUSH).
- Reset (async, rst==0):
  - pc=RESET_VECTOR, state=BOOT, fetch_count=0, misaligned=0.
  - This gives fetch_valid=0 and flush=0.
  - Takes effect immediately, in any state, including mid-FLUSH.
- States: BOOT, RUN, FLUSH, HALTED.
- BOOT: exactly one cycle, pc held, then RUN. All inputs ignored.
- RUN, priority redirect > halt > stall > advance:
  - redirect_valid: pc <= {redirect_target[15:1],1'b0}; misaligned <= redirect_target[0]; flush counter <= FLUSH_CYCLES-1; state -> FLUSH.
  - halt: pc holds; state -> HALTED.
  - stall: pc and fetch_count hold; stay in RUN (fetch_valid stays 1).
  - else: pc <= pc + INSTR_STEP, modulo 2^16 (16'hFFFE -> 16'h0000); fetch_count += 1, wrap at 16'hFFFF -> 0.
- FLUSH:
  - flush=1 and fetch_valid=0 for exactly FLUSH_CYCLES cycles; pc holds at the target.
  - stall and halt are ignored.
  - A new redirect_valid in FLUSH reloads pc (same alignment rule) and restarts the full FLUSH_CYCLES count.
  - At count 0 -> RUN; the first fetch_valid cycle presents the target address.
- HALTED:
  - pc holds, fetch_valid=0.
  - redirect_valid, stall and halt are ignored.
  - resume -> pc <= pc + INSTR_STEP, state -> RUN, fetch_count += 1.
- misaligned is cleared on every cycle that has no misaligned redirect.
- fetch_count increments only on sequential advances; redirects do not count.
- Width rules: all address arithmetic is unsigned 16-bit. Carry is discarded.

Decomposition:
- types_pkg gains:
  - pc_state_e: 2-bit enum, BOOT=0, RUN=1, FLUSH=2, HALTED=3.
  - PC_STEP constant (16'd2).
  - flush counter width localparam (3 bits).
- Sub-module: reuse the existing adder (pc, offset=INSTR_STEP -> sum) for pc_next_seq.
- The FSM and pc register live in pc_controller.

Test Plan:
- Reset/boot: hold rst=0 for 3 cycles, release -> pc=0000, state BOOT for 1 cycle, then RUN. pc reads 0000,0002,0004 on successive cycles; fetch_count=0,1,2.
- Stall: in RUN at pc=0006, stall=1 for 2 cycles -> pc stays 0006, fetch_valid=1, fetch_count frozen. Release -> 0008.
- Redirect + flush: at pc=0010, redirect_valid=1, target=0041 -> misaligned pulses 1. pc=0040, flush=1 for 2 cycles, then RUN with pc=0040, then 0042. A second redirect (target 0080) during the 1st flush cycle -> pc=0080, flush lasts 2 more cycles.
- Priority: redirect_valid, halt and stall all high at pc=0020 (target 0100) -> FLUSH with pc=0100; halt dropped; state never HALTED.
- Halt/resume: halt at pc=0030 -> HALTED, pc=0030; redirect_valid ignored for 5 cycles. Resume -> pc=0032, RUN.
- Wrap + reset mid-op: redirect to FFFC, let it run -> FFFE then 0000. Assert rst=0 mid-FLUSH -> pc=RESET_VECTOR and flush=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_controller_pkg.sv
// -----------------------------------------------------------------------------
// pc_controller_pkg
// Shared types and constants for the program-counter sequencer.
//   pc_state_e   : sequencer state, also exported on the debug/trace port
//   PC_STEP      : default byte increment between sequential fetches
//   PC_W         : address width
//   FLUSH_CNT_W  : width of the flush-cycle down-counter (covers 1..7 cycles)
//   align_pc()   : forces a byte address onto an instruction boundary
// -----------------------------------------------------------------------------
package pc_controller_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_HALTED = 2'd3
    } pc_state_e;

    localparam int          PC_W        = 16;
    localparam logic [15:0] PC_STEP     = 16'd2;
    localparam int          FLUSH_CNT_W = 3;

    // Instructions are 2-byte aligned; bit 0 of a target is dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/pc_controller_adder.sv
// -----------------------------------------------------------------------------
// pc_controller_adder
// Unsigned modulo-2^WIDTH adder used to form the sequential next PC.
// Ports:
//   i_a   : base address (current PC)
//   i_b   : offset (instruction step)
//   o_sum : i_a + i_b, carry discarded
// -----------------------------------------------------------------------------
module pc_controller_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/pc_controller.sv
// -----------------------------------------------------------------------------
// pc_controller
// Program-counter sequencer: owns the fetch address and decides each cycle
// whether to advance, hold (stall), redirect (with an IF/ID flush window) or
// halt.
// Ports:
//   clk             : system clock, rising edge
//   rst             : asynchronous reset, active low
//   stall           : hold PC and current fetch (RUN only)
//   redirect_valid  : taken branch/jump; redirect_target is the destination
//   redirect_target : byte address of redirect destination
//   halt            : halt decoded (RUN only)
//   resume          : leave HALTED
//   pc              : current fetch address (registered)
//   pc_next_seq     : pc + INSTR_STEP (combinational, link value)
//   fetch_valid     : high in RUN
//   flush           : high in FLUSH
//   misaligned      : one-cycle pulse after a redirect whose target bit 0 was set
//   state           : current pc_state_e (registered)
//   fetch_count     : number of sequential advances, wraps at 16 bits
// -----------------------------------------------------------------------------
module pc_controller
    import pc_controller_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] INSTR_STEP   = PC_STEP,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    input  logic        halt,
    input  logic        resume,
    output logic [15:0] pc,
    output logic [15:0] pc_next_seq,
    output logic        fetch_valid,
    output logic        flush,
    output logic        misaligned,
    output logic [1:0]  state,
    output logic [15:0] fetch_count
);

    // The counter is loaded with FLUSH_CYCLES-1 and FLUSH exits on the cycle
    // it reads zero, giving exactly FLUSH_CYCLES cycles of flush.
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    pc_state_e               r_state;
    pc_state_e               w_state_nxt;
    logic [PC_W-1:0]         r_pc;
    logic [PC_W-1:0]         w_pc_nxt;
    logic [PC_W-1:0]         w_pc_inc;
    logic [FLUSH_CNT_W-1:0]  r_flush_cnt;
    logic [FLUSH_CNT_W-1:0]  w_flush_cnt_nxt;
    logic [15:0]             r_fetch_count;
    logic [15:0]             w_fetch_count_nxt;
    logic                    r_misaligned;
    logic                    w_misaligned_nxt;

    pc_controller_adder #(
        .WIDTH (PC_W)
    ) u_adder (
        .i_a   (r_pc),
        .i_b   (INSTR_STEP),
        .o_sum (w_pc_inc)
    );

    // Next-state and datapath update. Redirects (RUN and FLUSH) share one
    // load path so a redirect inside FLUSH restarts the full window.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_flush_cnt_nxt   = r_flush_cnt;
        w_fetch_count_nxt = r_fetch_count;
        w_misaligned_nxt  = 1'b0;

        unique case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end

            ST_RUN: begin
                if (redirect_valid) begin
                    w_pc_nxt         = align_pc(redirect_target);
                    w_misaligned_nxt = redirect_target[0];
                    w_flush_cnt_nxt  = FLUSH_RELOAD;
                    w_state_nxt      = ST_FLUSH;
                end else if (halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (!stall) begin
                    w_pc_nxt          = w_pc_inc;
                    w_fetch_count_nxt = r_fetch_count + 16'd1;
                end
            end

            ST_FLUSH: begin
                if (redirect_valid) begin
                    w_pc_nxt         = align_pc(redirect_target);
                    w_misaligned_nxt = redirect_target[0];
                    w_flush_cnt_nxt  = FLUSH_RELOAD;
                end else if (r_flush_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - FLUSH_CNT_W'(1);
                end
            end

            ST_HALTED: begin
                if (resume) begin
                    w_pc_nxt          = w_pc_inc;
                    w_fetch_count_nxt = r_fetch_count + 16'd1;
                    w_state_nxt       = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_VECTOR;
            r_flush_cnt   <= '0;
            r_fetch_count <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_fetch_count <= w_fetch_count_nxt;
            r_misaligned  <= w_misaligned_nxt;
        end
    end

    assign pc          = r_pc;
    assign pc_next_seq = w_pc_inc;
    assign fetch_valid = (r_state == ST_RUN);
    assign flush       = (r_state == ST_FLUSH);
    assign misaligned  = r_misaligned;
    assign state       = r_state;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_controller.sv
// -----------------------------------------------------------------------------
// tb_pc_controller
// Scoreboard bench: the driver applies inputs on the falling edge, advances a
// behavioural model of the sequencer and queues the outputs expected after the
// next rising edge; a monitor pops and compares shortly after each rising edge.
// -----------------------------------------------------------------------------
module tb_pc_controller;

    localparam logic [15:0] RV    = 16'h0000;
    localparam logic [15:0] STEP  = 16'd2;
    localparam int          FLUSH = 2;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] pcns;
        logic [15:0] fcnt;
        logic [1:0]  st;
        logic        fv;
        logic        fl;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_target = 16'h0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [15:0] pc;
    logic [15:0] pc_next_seq;
    logic        fetch_valid;
    logic        flush;
    logic        misaligned;
    logic [1:0]  state;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // Model state: mode 0=BOOT 1=RUN 2=FLUSH 3=HALTED; m_left = flush cycles
    // still to be shown including the current one.
    logic [15:0] m_pc   = RV;
    logic [15:0] m_cnt  = 16'h0;
    int          m_mode = 0;
    int          m_left = 0;
    logic        m_mis  = 1'b0;

    pc_controller #(
        .RESET_VECTOR (RV),
        .INSTR_STEP   (STEP),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .resume          (resume),
        .pc              (pc),
        .pc_next_seq     (pc_next_seq),
        .fetch_valid     (fetch_valid),
        .flush           (flush),
        .misaligned      (misaligned),
        .state           (state),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rs, input bit st, input bit rv,
                              input logic [15:0] rt, input bit h, input bit rsm);
        exp_t e;
        bit   take;
        take = 0;
        if (!rs) begin
            m_pc = RV; m_cnt = 16'h0; m_mode = 0; m_left = 0; m_mis = 1'b0;
        end else begin
            m_mis = 1'b0;
            case (m_mode)
                0: m_mode = 1;
                1: begin
                    if (rv) take = 1;
                    else if (h) m_mode = 3;
                    else if (!st) begin m_pc = m_pc + STEP; m_cnt = m_cnt + 16'd1; end
                end
                2: begin
                    if (rv) take = 1;
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_mode = 1;
                    end
                end
                default: begin
                    if (rsm) begin m_pc = m_pc + STEP; m_cnt = m_cnt + 16'd1; m_mode = 1; end
                end
            endcase
            if (take) begin
                m_pc   = rt & 16'hFFFE;
                m_mis  = rt[0];
                m_mode = 2;
                m_left = FLUSH;
            end
        end
        e.pc   = m_pc;
        e.pcns = m_pc + STEP;
        e.fcnt = m_cnt;
        e.st   = 2'(m_mode);
        e.fv   = (m_mode == 1);
        e.fl   = (m_mode == 2);
        e.mis  = m_mis;
        q.push_back(e);
    endtask

    task automatic drive(input bit rs, input bit st, input bit rv,
                         input logic [15:0] rt, input bit h, input bit rsm);
        @(negedge clk);
        rst = rs; stall = st; redirect_valid = rv; redirect_target = rt;
        halt = h; resume = rsm;
        model_step(rs, st, rv, rt, h, rsm);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1, 0, 0, 16'h0, 0, 0);
    endtask

    // Reset asserted between clock edges must act at once.
    task automatic async_reset;
        @(negedge clk);
        chk("pre_rst_flush", {15'h0, flush}, {15'h0, m_mode == 2});
        rst = 1'b0; stall = 0; redirect_valid = 0; halt = 0; resume = 0;
        #1;
        chk("async_pc", pc, RV);
        chk("async_flush", {15'h0, flush}, 16'h0);
        chk("async_fv", {15'h0, fetch_valid}, 16'h0);
        chk("async_state", {14'h0, state}, 16'h0);
        chk("async_fcnt", fetch_count, 16'h0);
        model_step(0, 0, 0, 16'h0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_next_seq", pc_next_seq, e.pcns);
                chk("fetch_count", fetch_count, e.fcnt);
                chk("state", {14'h0, state}, {14'h0, e.st});
                chk("fetch_valid", {15'h0, fetch_valid}, {15'h0, e.fv});
                chk("flush", {15'h0, flush}, {15'h0, e.fl});
                chk("misaligned", {15'h0, misaligned}, {15'h0, e.mis});
            end
        end
    end

    initial begin : stimulus
        int guard;
        bit rs, st, rv, h, rsm;
        logic [15:0] rt;

        repeat (3) drive(0, 0, 0, 16'h0, 0, 0);   // reset held 3 cycles
        idle(4);                                  // BOOT, then 0000,0002,0004,0006
        repeat (2) drive(1, 1, 0, 16'h0, 0, 0);   // stall
        idle(5);
        drive(1, 0, 1, 16'h0041, 0, 0);           // misaligned redirect
        drive(1, 0, 1, 16'h0080, 0, 0);           // redirect inside FLUSH
        idle(4);
        drive(1, 1, 1, 16'h0100, 1, 0);           // redirect beats halt and stall
        idle(4);
        drive(1, 0, 0, 16'h0, 1, 0);              // halt
        repeat (5) drive(1, 1, 1, 16'h1235, 1, 0); // ignored while halted
        drive(1, 0, 0, 16'h0, 0, 1);              // resume
        idle(2);
        drive(1, 0, 1, 16'hFFFC, 0, 0);           // run through the wrap
        idle(6);
        drive(1, 0, 1, 16'h0200, 0, 0);
        async_reset();                            // mid-FLUSH
        drive(0, 0, 0, 16'h0, 0, 0);
        idle(3);

        for (int i = 0; i < 600; i++) begin
            rs  = ($urandom % 150) != 0;
            st  = ($urandom % 4) == 0;
            rv  = ($urandom % 8) == 0;
            h   = ($urandom % 16) == 0;
            rsm = ($urandom % 4) == 0;
            rt  = 16'($urandom);
            if (($urandom % 4) == 0) rt = 16'($urandom_range(16'hFFF0, 16'hFFFF));
            drive(rs, st, rv, rt, h, rsm);
        end
        idle(2);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
